// File: rtl/vga_tile_engine.sv
// Pixel source for the VGA timing controller.
// Converts row_addr/col_addr/rdn into a 12-bit rrrr_gggg_bbbb pixel word.
// Pixels come from a double-buffered 40x30 map of 16x16 tiles, indexed
// through a 16-entry palette, with an optional blinking inverted cursor.
// Bank swaps requested by the writer are deferred to the frame-start cycle
// so that a swap never tears the picture.
module vga_tile_engine #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [11:0] d_out,
    input  logic        wr_en,
    input  logic [5:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [3:0]  wr_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_data,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        swap_done,
    input  logic        cursor_en,
    input  logic [5:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    output logic [7:0]  frame_cnt
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam logic [5:0] COL_LIM = 6'(COLS);
    localparam logic [4:0] ROW_LIM = 5'(ROWS);

    // Two map banks, asynchronous read, synchronous write.
    logic [3:0]  bank0 [2048];
    logic [3:0]  bank1 [2048];
    logic [11:0] palette [16];

    logic [0:0]  state;
    logic        front_bank;

    // Read-side decode
    logic [5:0]  tx;
    logic [4:0]  ty;
    logic [10:0] rd_addr;
    logic [3:0]  px;
    logic [11:0] colour;
    logic        in_range;
    logic        cursor_hit;
    logic        frame_start;

    // Write-side decode
    logic [10:0] wr_addr;
    logic        wr_ok;
    logic        do_swap;

    assign tx       = col_addr[9:4];
    assign ty       = row_addr[8:4];
    assign rd_addr  = {ty, tx};
    assign in_range = (tx < COL_LIM) && (ty < ROW_LIM);
    assign px       = front_bank ? bank1[rd_addr] : bank0[rd_addr];
    assign colour   = palette[px];

    assign cursor_hit = cursor_en && (tx == cursor_x) && (ty == cursor_y)
                        && frame_cnt[BLINK_LOG2];

    // The controller presents exactly one (0,0) read per frame.
    assign frame_start = !rdn && (row_addr == 9'd0) && (col_addr == 10'd0);

    assign wr_addr = {wr_y, wr_x};
    assign wr_ok   = wr_en && (wr_x < COL_LIM) && (wr_y < ROW_LIM);

    // A swap fires on frame start if one is waiting or arrives right then.
    assign do_swap = frame_start && ((state == PENDING) || swap_req);

    assign swap_pending = (state == PENDING);

    // Pixel output: blank outside the map or when not reading.
    always_comb begin
        d_out = 12'h000;
        if (!rdn && in_range) begin
            if (cursor_hit) begin
                d_out = colour ^ 12'hFFF;
            end else begin
                d_out = colour;
            end
        end
    end

    // Back-bank write into bank 0 (only while bank 1 is on screen).
    always_ff @(posedge vga_clk) begin
        if (wr_ok && front_bank) begin
            bank0[wr_addr] <= wr_data;
        end
    end

    // Back-bank write into bank 1 (only while bank 0 is on screen).
    always_ff @(posedge vga_clk) begin
        if (wr_ok && !front_bank) begin
            bank1[wr_addr] <= wr_data;
        end
    end

    // Palette: grey ramp after reset, new entries visible next cycle.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

    // Frame counter advances once per frame-start cycle.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            frame_cnt <= 8'd0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Swap FSM: hold a request until frame start, then flip the banks.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            front_bank <= 1'b0;
            swap_done  <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (do_swap) begin
                front_bank <= ~front_bank;
                swap_done  <= 1'b1;
                state      <= IDLE;
            end else if ((state == IDLE) && swap_req) begin
                state <= PENDING;
            end
        end
    end

endmodule
